// File: rtl/user_rd_reg_pkg.sv
// Shared definitions for the JTAG user read register: FSM state encoding
// and the elaboration-time clog2 used to size the bit counter.
package user_rd_reg_pkg;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_CAPT = 2'd1,
        RD_SHFT = 2'd2,
        RD_CMPL = 2'd3
    } rd_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/user_rd_reg.sv
// JTAG user read register: captures a fabric word, shifts it out LSB-first,
// and reports at Update-DR whether the host read the whole word.
module user_rd_reg
    import user_rd_reg_pkg::*;
#(
    parameter int width = 8,
    parameter logic [width-1:0] def_value = '0,
    localparam int CW = clog2(width + 1)
) (
    input  logic             TCK,
    input  logic             RST_N,
    input  logic             FSEL,
    input  logic             SEL,
    input  logic             TDI,
    input  logic             DSY_IN,
    input  logic             DSY_CHAIN,
    input  logic             CAPTURE,
    input  logic             SHIFT,
    input  logic             UPDATE,
    input  logic [width-1:0] PI,
    input  logic             PI_VLD,
    output logic             TDO,
    output logic             DSY_OUT,
    output logic [CW-1:0]    BIT_CNT,
    output logic             STALE,
    output logic             RD_ACK,
    output logic             RD_ABORT
);

    localparam logic [CW-1:0] CNT_MAX  = CW'(width);
    localparam logic [CW-1:0] CNT_LAST = CW'(width - 1);

    rd_state_t        state, state_nxt;
    logic [width-1:0] d;
    logic [CW-1:0]    bit_cnt;
    logic             stale;
    logic             act, din;
    logic             do_cap, do_shift, do_upd;
    logic             ack_nxt, abort_nxt;

    assign act      = SEL & (FSEL | DSY_CHAIN);
    assign din      = DSY_CHAIN ? DSY_IN : TDI;
    assign do_cap   = act & CAPTURE;
    assign do_shift = act & SHIFT & ~CAPTURE;
    assign do_upd   = act & UPDATE & ~CAPTURE & ~SHIFT;

    assign TDO     = FSEL & d[0];
    assign DSY_OUT = DSY_CHAIN & d[0];
    assign BIT_CNT = bit_cnt;
    assign STALE   = stale;

    always_comb begin
        state_nxt = state;
        ack_nxt   = 1'b0;
        abort_nxt = 1'b0;
        if (do_cap) begin
            state_nxt = RD_CAPT;
        end else if (do_shift) begin
            // A shift in IDLE or COMPLETE moves data only; the read state holds.
            case (state)
                RD_CAPT, RD_SHFT: state_nxt = (bit_cnt == CNT_LAST) ? RD_CMPL : RD_SHFT;
                default:          state_nxt = state;
            endcase
        end else if (do_upd) begin
            case (state)
                RD_CMPL: begin
                    state_nxt = RD_IDLE;
                    ack_nxt   = 1'b1;
                end
                RD_CAPT, RD_SHFT: begin
                    state_nxt = RD_IDLE;
                    abort_nxt = 1'b1;
                end
                default: state_nxt = RD_IDLE;
            endcase
        end
    end

    always_ff @(posedge TCK) begin
        if (!RST_N) begin
            state    <= RD_IDLE;
            d        <= def_value;
            bit_cnt  <= '0;
            stale    <= 1'b0;
            RD_ACK   <= 1'b0;
            RD_ABORT <= 1'b0;
        end else begin
            state    <= state_nxt;
            RD_ACK   <= ack_nxt;
            RD_ABORT <= abort_nxt;
            if (do_cap) begin
                d       <= PI;
                bit_cnt <= '0;
                stale   <= ~PI_VLD;
            end else if (do_shift) begin
                // Shifting continues past a full word so chained registers see pass-through data.
                d <= {din, d[width-1:1]};
                if (bit_cnt != CNT_MAX) begin
                    bit_cnt <= bit_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_user_rd_reg.sv
// Self-checking bench for user_rd_reg: directed vector table, hand-written
// corner sequences, then randomized traffic against a transaction-level model.
module tb_user_rd_reg;

    localparam int W = 8;

    logic       TCK = 1'b0;
    logic       RST_N, FSEL, SEL, TDI, DSY_IN, DSY_CHAIN, CAPTURE, SHIFT, UPDATE, PI_VLD;
    logic [7:0] PI;
    logic       TDO, DSY_OUT, STALE, RD_ACK, RD_ABORT;
    logic [3:0] BIT_CNT;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the word being read, how many bits the host has pulled
    // since the last capture, and whether a capture is still awaiting its update.
    logic [7:0] m_d;
    int         m_cnt;
    logic       m_stale, m_pend, m_ack, m_abort;

    typedef struct {
        logic       rst_n, fsel, sel, chain, tdi, dsy_in, cap, sh, upd;
        logic [7:0] pi;
        logic       vld;
        logic       e_tdo, e_dsy;
        logic [3:0] e_cnt;
        logic       e_stale, e_ack, e_abort;
    } vec_t;

    vec_t tbl[$];

    always #5 TCK = ~TCK;

    user_rd_reg #(.width(8), .def_value(8'h00)) dut (
        .TCK(TCK), .RST_N(RST_N), .FSEL(FSEL), .SEL(SEL), .TDI(TDI),
        .DSY_IN(DSY_IN), .DSY_CHAIN(DSY_CHAIN), .CAPTURE(CAPTURE), .SHIFT(SHIFT),
        .UPDATE(UPDATE), .PI(PI), .PI_VLD(PI_VLD), .TDO(TDO), .DSY_OUT(DSY_OUT),
        .BIT_CNT(BIT_CNT), .STALE(STALE), .RD_ACK(RD_ACK), .RD_ABORT(RD_ABORT)
    );

    function automatic vec_t row(input logic cap, sh, upd, input logic [7:0] pi, input logic vld,
                                 input logic e_tdo, input logic [3:0] e_cnt,
                                 input logic e_stale, e_ack, e_abort);
        vec_t v;
        v.rst_n = 1'b1; v.fsel = 1'b1; v.sel = 1'b1; v.chain = 1'b0;
        v.tdi = 1'b0; v.dsy_in = 1'b0;
        v.cap = cap; v.sh = sh; v.upd = upd; v.pi = pi; v.vld = vld;
        v.e_tdo = e_tdo; v.e_dsy = 1'b0; v.e_cnt = e_cnt;
        v.e_stale = e_stale; v.e_ack = e_ack; v.e_abort = e_abort;
        return v;
    endfunction

    task automatic cyc(input logic rst_n, fsel, sel, chain, tdi, dsy_in, cap, sh, upd,
                       input logic [7:0] pi, input logic vld);
        RST_N = rst_n; FSEL = fsel; SEL = sel; DSY_CHAIN = chain; TDI = tdi; DSY_IN = dsy_in;
        CAPTURE = cap; SHIFT = sh; UPDATE = upd; PI = pi; PI_VLD = vld;
        @(posedge TCK);
        if (!rst_n) begin
            m_d = 8'h00; m_cnt = 0; m_stale = 1'b0; m_pend = 1'b0; m_ack = 1'b0; m_abort = 1'b0;
        end else begin
            m_ack = 1'b0;
            m_abort = 1'b0;
            if (sel && (fsel || chain)) begin
                if (cap) begin
                    m_d = pi; m_cnt = 0; m_stale = !vld; m_pend = 1'b1;
                end else if (sh) begin
                    m_d = {(chain ? dsy_in : tdi), m_d[7:1]};
                    if (m_cnt < W) m_cnt++;
                end else if (upd) begin
                    if (m_pend) begin
                        if (m_cnt == W) m_ack = 1'b1;
                        else m_abort = 1'b1;
                    end
                    m_pend = 1'b0;
                end
            end
        end
        #1;
    endtask

    task automatic chk(input string nm, input logic e_tdo, e_dsy, input logic [3:0] e_cnt,
                       input logic e_stale, e_ack, e_abort);
        n_cmp++;
        if ({TDO, DSY_OUT, BIT_CNT, STALE, RD_ACK, RD_ABORT} !==
            {e_tdo, e_dsy, e_cnt, e_stale, e_ack, e_abort}) begin
            n_bad++;
            $display("FAIL %s: got tdo=%b dsy=%b cnt=%0d stale=%b ack=%b abort=%b, expected tdo=%b dsy=%b cnt=%0d stale=%b ack=%b abort=%b",
                     nm, TDO, DSY_OUT, BIT_CNT, STALE, RD_ACK, RD_ABORT,
                     e_tdo, e_dsy, e_cnt, e_stale, e_ack, e_abort);
        end
    endtask

    initial begin
        vec_t v;
        logic [7:0] a5_seq;
        logic [4:0] c3_seq;
        logic [9:0] dsy_seq;

        // Reset held with an active shift request, then release and a no-op update.
        v = row(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        v.rst_n = 1'b0; v.tdi = 1'b1;
        tbl.push_back(v);
        tbl.push_back(v);
        tbl.push_back(row(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
        tbl.push_back(row(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0));

        // Full read of 8'hA5: TDO after each shift is the next bit up.
        a5_seq = 8'b0101_0010;
        tbl.push_back(row(1'b1, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0));
        for (int k = 1; k <= 8; k++)
            tbl.push_back(row(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, a5_seq[k-1], 4'(k), 1'b0, 1'b0, 1'b0));
        tbl.push_back(row(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 4'd8, 1'b0, 1'b1, 1'b0));
        tbl.push_back(row(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 4'd8, 1'b0, 1'b0, 1'b0));

        // Short read of 8'h3C: five shifts then update.
        c3_seq = 5'b11110;
        tbl.push_back(row(1'b1, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0));
        for (int k = 1; k <= 5; k++)
            tbl.push_back(row(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, c3_seq[k-1], 4'(k), 1'b0, 1'b0, 1'b0));
        tbl.push_back(row(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 1'b1));
        tbl.push_back(row(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0));

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            cyc(v.rst_n, v.fsel, v.sel, v.chain, v.tdi, v.dsy_in, v.cap, v.sh, v.upd, v.pi, v.vld);
            chk($sformatf("vec%0d", i), v.e_tdo, v.e_dsy, v.e_cnt, v.e_stale, v.e_ack, v.e_abort);
        end

        // Stale capture still acknowledged; cleared by the next valid capture.
        cyc(1, 1, 1, 0, 0, 0, 1, 0, 0, 8'hFF, 0);
        chk("stale_cap", 1, 0, 4'd0, 1, 0, 0);
        for (int k = 1; k <= 8; k++) cyc(1, 1, 1, 0, 0, 0, 0, 1, 0, 8'h00, 0);
        chk("stale_shift8", 0, 0, 4'd8, 1, 0, 0);
        cyc(1, 1, 1, 0, 0, 0, 0, 0, 1, 8'h00, 0);
        chk("stale_ack", 0, 0, 4'd8, 1, 1, 0);
        cyc(1, 1, 1, 0, 0, 0, 1, 0, 0, 8'h00, 1);
        chk("stale_clear", 0, 0, 4'd0, 0, 0, 0);

        // Daisy chain: TDI held opposite to DSY_IN to show the input mux.
        cyc(1, 0, 1, 1, 0, 1, 1, 0, 0, 8'h81, 1);
        chk("dsy_cap", 0, 1, 4'd0, 0, 0, 0);
        dsy_seq = 10'b11_1100_0000;
        for (int k = 1; k <= 10; k++) begin
            cyc(1, 0, 1, 1, 0, 1, 0, 1, 0, 8'h00, 1);
            chk($sformatf("dsy_sh%0d", k), 0, dsy_seq[k-1], 4'((k > 8) ? 8 : k), 0, 0, 0);
        end
        cyc(1, 0, 1, 1, 0, 1, 0, 0, 1, 8'h00, 1);
        chk("dsy_upd", 0, 1, 4'd8, 0, 1, 0);

        // Collisions, inactive select, and reset in the middle of a read.
        cyc(1, 1, 1, 0, 1, 0, 1, 1, 0, 8'h5A, 1);
        chk("cap_shift", 0, 0, 4'd0, 0, 0, 0);
        for (int k = 1; k <= 4; k++) cyc(1, 1, 1, 0, 1, 0, 0, 1, 0, 8'h00, 1);
        chk("shift4", 1, 0, 4'd4, 0, 0, 0);
        cyc(1, 1, 0, 0, 1, 0, 1, 1, 1, 8'hFF, 0);
        chk("sel0", 1, 0, 4'd4, 0, 0, 0);
        cyc(1, 1, 0, 0, 1, 0, 0, 0, 1, 8'hFF, 0);
        chk("sel0_upd", 1, 0, 4'd4, 0, 0, 0);
        cyc(0, 1, 1, 0, 1, 0, 0, 1, 0, 8'h00, 1);
        chk("rst_mid", 0, 0, 4'd0, 0, 0, 0);
        cyc(1, 1, 1, 0, 1, 0, 0, 0, 1, 8'h00, 1);
        chk("rst_idle_upd", 0, 0, 4'd0, 0, 0, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 59) != 0), 1'($urandom), ($urandom_range(0, 7) != 0),
                1'($urandom), 1'($urandom), 1'($urandom),
                ($urandom_range(0, 11) == 0), ($urandom_range(0, 2) != 0),
                ($urandom_range(0, 5) == 0), 8'($urandom), ($urandom_range(0, 3) != 0));
            chk($sformatf("rand%0d", i), FSEL & m_d[0], DSY_CHAIN & m_d[0], 4'(m_cnt),
                m_stale, m_ack, m_abort);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
